// File: rtl/wptr_ctrl.sv
// Write-side pointer controller for a synchronous FIFO of arbitrary depth.
// Produces wrap-bit write pointer, occupancy, full/almost-full, write ack and sticky overflow.
module wptr_ctrl #(
  parameter int DEPTH      = 90,
  parameter int ADDRSIZE   = 8,
  parameter int AF_DEFAULT = DEPTH - 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic [ADDRSIZE-1:0]   rptr,
  input  logic                  waf_load,
  input  logic [ADDRSIZE-1:0]   waf_thresh,
  output logic [ADDRSIZE-1:0]   wptr,
  output logic [ADDRSIZE-2:0]   waddr,
  output logic                  wmem_we,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDRSIZE-1:0]   wlevel,
  output logic                  wack,
  output logic                  woverflow
);

  localparam int IW = ADDRSIZE - 1;
  localparam logic [IW-1:0]       LAST_IDX = IW'(DEPTH - 1);
  localparam logic [ADDRSIZE-1:0] DEPTH_W  = ADDRSIZE'(DEPTH);
  localparam logic [ADDRSIZE-1:0] AF_INIT  = ADDRSIZE'(AF_DEFAULT);

  logic [ADDRSIZE-1:0] wptr_q, wptr_d;
  logic [ADDRSIZE-1:0] thresh_q, thresh_d;
  logic                wack_q, wack_d;
  logic                wovf_q, wovf_d;

  logic [IW-1:0]       widx_s, ridx_s;
  logic                wwrap_s, rwrap_s;
  logic                full_s, accept_s;
  logic [ADDRSIZE-1:0] level_s;

  assign widx_s  = wptr_q[IW-1:0];
  assign ridx_s  = rptr[IW-1:0];
  assign wwrap_s = wptr_q[ADDRSIZE-1];
  assign rwrap_s = rptr[ADDRSIZE-1];

  // Status decode and next-state computation.
  always_comb begin
    wptr_d   = wptr_q;
    thresh_d = thresh_q;
    full_s   = (wwrap_s != rwrap_s) && (widx_s == ridx_s);
    accept_s = wr_en & ~full_s;
    if (wwrap_s == rwrap_s) begin
      level_s = {1'b0, widx_s} - {1'b0, ridx_s};
    end else begin
      level_s = DEPTH_W - {1'b0, ridx_s} + {1'b0, widx_s};
    end
    // Any index at or beyond the last slot wraps, which also recovers from corrupt pointers.
    if (accept_s) begin
      if (widx_s >= LAST_IDX) begin
        wptr_d = {~wwrap_s, {IW{1'b0}}};
      end else begin
        wptr_d = {wwrap_s, widx_s + IW'(1)};
      end
    end else begin
      wptr_d = wptr_q;
    end
    if (waf_load) begin
      thresh_d = waf_thresh;
    end else begin
      thresh_d = thresh_q;
    end
    wack_d = accept_s;
    wovf_d = wovf_q | (wr_en & full_s);
  end

  // State registers with synchronous reset.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wptr_q   <= {ADDRSIZE{1'b0}};
      thresh_q <= AF_INIT;
      wack_q   <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      thresh_q <= thresh_d;
      wack_q   <= wack_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wptr         = wptr_q;
  assign waddr        = widx_s;
  assign wmem_we      = accept_s;
  assign wfull        = full_s;
  assign wlevel       = level_s;
  assign walmost_full = (level_s >= thresh_q);
  assign wack         = wack_q;
  assign woverflow    = wovf_q;

endmodule

// File: doc/wptr_ctrl.md
Name: wptr_ctrl

Overview:
- Single-clock write-side pointer controller for synchronous FIFOs of arbitrary, non-power-of-two depth.
- Generalises the wrap-bit write pointer scheme with an occupancy count, a programmable almost-full flag, a registered write acknowledge, a sticky overflow flag and a RAM write strobe.
- Sits between the producer and the FIFO RAM.
- Consumes a read pointer from a read controller in the same clock domain.

Parameters:
- DEPTH, 90, number of FIFO entries (2 to 2^(ADDRSIZE-1)).
- ADDRSIZE, 8, pointer width: MSB is the wrap bit, bits [ADDRSIZE-2:0] are the entry index.
- AF_DEFAULT, DEPTH-4, almost-full threshold loaded at reset.

Ports:
- wr_clk  input  1  clock; all logic on rising edge.
- wr_rst  input  1  synchronous reset, active-high.
- wr_en  input  1  producer write request.
- rptr  input  ADDRSIZE  read pointer (same format, same clock domain).
- waf_load  input  1  load new almost-full threshold.
- waf_thresh  input  ADDRSIZE  threshold value loaded when waf_load=1.
- wptr  output  ADDRSIZE  registered write pointer {wrap, index}.
- waddr  output  ADDRSIZE-1  RAM write address (= wptr index bits).
- wmem_we  output  1  RAM write strobe, combinational: wr_en & !wfull.
- wfull  output  1  FIFO full, combinational from wptr/rptr.
- walmost_full  output  1  wlevel >= active threshold, combinational.
- wlevel  output  ADDRSIZE  occupancy 0..DEPTH, combinational.
- wack  output  1  registered; high one cycle after an accepted write.
- woverflow  output  1  sticky registered; write attempted while full.

Behaviour:
- Reset (wr_rst=1 at a clock edge): wptr=0, wack=0, woverflow=0, threshold=AF_DEFAULT. Reset overrides every other input in that cycle.
- Reset outputs with rptr=0: wfull=0, wlevel=0. walmost_full=0 unless the threshold is 0.
- Accepted write = wr_en & !wfull, evaluated on current wptr/rptr.
- On an accepted write:
  - Index < DEPTH-1: index+1, wrap bit held.
  - Index == DEPTH-1: index=0, wrap bit toggled.
  - Index values >= DEPTH never occur. If reached by an rptr/wptr fault, the next accepted write forces index=0 and toggles wrap.
- Rejected write (wr_en=1, wfull=1): wptr holds. woverflow=1 from the next cycle until reset. wack=0.
- wack: registered copy of the accepted-write condition, so latency is exactly 1 cycle.
- wfull = (wptr wrap != rptr wrap) && (index bits equal).
- wlevel:
  - Wrap bits equal: wptr.idx - rptr.idx.
  - Wrap bits differ: DEPTH - rptr.idx + wptr.idx.
  - Computed at ADDRSIZE width, no overflow for DEPTH <= 2^(ADDRSIZE-1).
- Empty (wlevel=0) is not an output; the read side owns empty.
- Threshold: register loaded from waf_thresh on waf_load (not during reset).
  - Threshold 0: walmost_full is always 1.
  - Threshold > DEPTH: walmost_full is never 1.
  - New value takes effect the cycle after the load.
- Same-cycle write and read: full is judged on the current rptr. A write at full is rejected even if rptr advances that edge; the producer retries the next cycle. The level then reflects both updates.
- Reset mid-stream: pointer returns to 0. The read side must be reset in the same cycle; no recovery logic is provided.

Test Plan:
- Fill: DEPTH=90, ADDRSIZE=8, rptr=0, wr_en=1 for 90 cycles after reset.
  - wptr 0x00→0x80, waddr 0..89 then 0.
  - wack pulses 90 cycles.
  - After the 90th write: wfull=1, wlevel=90.
- Overflow: from full, hold wr_en 3 more cycles.
  - wmem_we=0, wptr stays 0x80, wack=0.
  - woverflow=1 from the next cycle, still 1 after wr_en drops.
  - Only wr_rst clears it.
- Wrap level: rptr=0x55 (idx 85), drive wptr to 0x83.
  - wlevel=90-85+3=8, wfull=0.
  - Then rptr=0x03: wfull=1, wlevel=90.
- Almost-full: waf_load=1, waf_thresh=10, fill from empty.
  - walmost_full rises exactly when wlevel reaches 10.
  - Load 0: walmost_full=1 at wlevel=0. Load 91: never asserts at full.
- Simultaneous events:
  - At full with rptr advancing in the same cycle and wr_en=1: write rejected, accepted next cycle.
  - wr_rst=1 with wr_en=1 at wlevel=40: wptr=0, wack=0 next cycle.
- Reset default threshold: after reset with no load, walmost_full asserts first at wlevel=86.
